// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the memory copy engine.
package mem_copy_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_ctr.sv
// Loadable up-counter with a terminal-value compare, used as the copy byte index.
module mem_copy_ctr #(
  parameter int unsigned Width = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [Width-1:0] term_i,
  output logic [Width-1:0] count_o,
  output logic             at_term_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (inc_i) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count_o   = count_q;
  assign at_term_o = (count_q == term_i);

endmodule

// File: rtl/mem_copy_engine.sv
// Memory front end: CPU pass-through when idle, byte-wise block copy when started.
// Optional block fill mode is enabled by defining MEM_COPY_FILL_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int unsigned W = DATA_W,
  parameter int unsigned A = ADDR_W
) (
  input  logic         Clk,
  input  logic         Reset,
`ifdef MEM_COPY_FILL_EN
  input  logic         Fill,
  input  logic [W-1:0] FillValue,
`endif
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A-1:0] Len,
  output logic         Busy,
  output logic         Done,
  input  logic         CpuWriteEn,
  input  logic [A-1:0] CpuAddr,
  input  logic [W-1:0] CpuDataIn,
  output logic [W-1:0] CpuDataOut,
  output logic         MemWriteEn,
  output logic [A-1:0] MemAddress,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut
);

  state_e state_q, state_d;

  logic [A-1:0] src_q, dst_q, len_q;
  logic [W-1:0] hold_q;
  logic [A-1:0] idx;
  logic         idx_last;
  logic         idx_load, idx_inc;
  logic         start_go;

  state_e       first_st;
  state_e       loop_st;
  logic [W-1:0] wr_data;

  assign start_go = (state_q == StIdle) && Start;

`ifdef MEM_COPY_FILL_EN
  logic         fill_q;
  logic [W-1:0] fill_val_q;

  // Fill mode skips the read phase entirely.
  assign first_st = Fill ? StWrite : StRead;
  assign loop_st  = fill_q ? StWrite : StRead;
  assign wr_data  = fill_q ? fill_val_q : hold_q;
`else
  assign first_st = StRead;
  assign loop_st  = StRead;
  assign wr_data  = hold_q;
`endif

  mem_copy_ctr #(
    .Width(A)
  ) u_idx_ctr (
    .Clk       (Clk),
    .Reset     (Reset),
    .load_i    (idx_load),
    .load_val_i('0),
    .inc_i     (idx_inc),
    .term_i    (len_q - A'(1)),
    .count_o   (idx),
    .at_term_o (idx_last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      hold_q     <= '0;
`ifdef MEM_COPY_FILL_EN
      fill_q     <= 1'b0;
      fill_val_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (start_go) begin
        src_q      <= SrcAddr;
        dst_q      <= DstAddr;
        len_q      <= Len;
`ifdef MEM_COPY_FILL_EN
        fill_q     <= Fill;
        fill_val_q <= FillValue;
`endif
      end
      if (state_q == StRead) begin
        hold_q <= MemDataOut;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    Busy       = 1'b1;
    Done       = 1'b0;
    MemWriteEn = 1'b0;
    MemAddress = CpuAddr;
    MemDataIn  = wr_data;
    CpuDataOut = '0;
    idx_load   = 1'b0;
    idx_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        Busy       = 1'b0;
        MemWriteEn = CpuWriteEn;
        MemAddress = CpuAddr;
        MemDataIn  = CpuDataIn;
        CpuDataOut = MemDataOut;
        if (Start) begin
          idx_load = 1'b1;
          state_d  = (Len == '0) ? StDone : first_st;
        end
      end
      StRead: begin
        MemAddress = src_q + idx;
        state_d    = StWrite;
      end
      StWrite: begin
        MemAddress = dst_q + idx;
        MemWriteEn = 1'b1;
        if (idx_last) begin
          state_d = StDone;
        end else begin
          idx_inc = 1'b1;
          state_d = loop_st;
        end
      end
      StDone: begin
        Done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
